ldst_unit: RTL and testbench
============================

Name: ldst_unit

Overview:
- Multi-cycle load/store sequencer between the instruction decoder and data memory.
- Accepts one load or store command per transaction and drives the data-memory port.
- For loads, waits out the memory latency, then issues the register-file write strobe (WriteEn / Op / Operation / Rtaddr / DataIn). It is the initiator side of the register-file write interface.
- Sits in the execute stage; the decoder stalls the PC while Busy is high.

Parameters:
- W, 8, data path / address width.
- A, 4, register address width (2**A registers).
- MEM_LAT, 2, data-memory read latency in cycles; legal range 1..15.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous, active-low reset.
- Start  input  1  command strobe from decoder; sampled only in IDLE.
- Operation  input  4  command opcode (kLOD or kSTR from Definitions).
- Rtaddr  input  A  destination register for a load (ignored for a store).
- AddrIn  input  W  memory address, taken from register r0.
- StoreData  input  W  store data, taken from register Rtaddr.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle completion pulse.
- Err  output  1  one-cycle pulse on an illegal opcode.
- MemAddr  output  W  data-memory address.
- MemRdEn  output  1  data-memory read enable.
- MemWrEn  output  1  data-memory write enable.
- MemDataOut  output  W  data-memory write data.
- MemDataIn  input  W  data-memory read data.
- RfWriteEn  output  1  register-file write enable.
- RfOp  output  1  register-file I-type flag; always 0 from this block.
- RfOperation  output  4  register-file operation; kLOD during writeback.
- RfRtaddr  output  A  register-file target address.
- RfDataIn  output  W  register-file write data.

Behaviour:
- States: IDLE, RD, WB, ST, DONE. All outputs are Moore outputs decoded from the state register and the latched command registers.
- Reset low (checked at the clock edge):
  - state=IDLE; latched addr, data, rt and counter cleared to 0.
  - All strobes (MemRdEn, MemWrEn, RfWriteEn, Done, Err) are 0; all data/address outputs are 0.
- IDLE, Start=1:
  - Latch AddrIn, StoreData, Rtaddr and Operation.
  - Operation==kLOD: go to RD, counter=MEM_LAT-1.
  - Operation==kSTR: go to ST.
  - Any other opcode: Err=1 in the next cycle, remain in IDLE, no memory or register-file activity.
- Start while Busy=1 is ignored and does not queue.
- RD:
  - MemRdEn=1 and MemAddr=latched addr, held for MEM_LAT cycles.
  - Counter decrements each cycle.
  - When counter==0, MemDataIn is captured at that edge and the state goes to WB.
- WB (1 cycle): RfWriteEn=1, RfOperation=kLOD, RfRtaddr=latched rt, RfDataIn=captured data; next state DONE.
- ST (1 cycle): MemWrEn=1, MemAddr=latched addr, MemDataOut=latched data; next state DONE.
- DONE (1 cycle): Done=1; next state IDLE. Start can be accepted in the cycle after DONE.
- Latency, with Start sampled at edge 0:
  - Load: RD for cycles 1..MEM_LAT, WB in cycle MEM_LAT+1, Done in cycle MEM_LAT+2.
  - Store: ST in cycle 1, Done in cycle 2.
- MemRdEn and MemWrEn are never high in the same cycle. RfWriteEn is high only in WB.
- Outside their active states, RfRtaddr, RfDataIn and MemDataOut hold their latched values. RfOperation outputs 0 outside WB.
- Reset asserted mid-transaction: the transaction is aborted, the next cycle is IDLE, and no register-file write or Done is issued for it.
- Address arithmetic: none; no wrap handling is needed, since the address is passed through at W bits.
- A store with address 2**W-1 is legal.

Decomposition:
- Definitions package:
  - kLOD and kSTR opcode constants (shared with the decoder and register file).
  - New enum ldst_state_t {IDLE, RD, WB, ST, DONE}.
- Latency counter width is $clog2(MEM_LAT+1), computed locally.
- No sub-module; a single FSM plus latch registers, roughly 150-200 lines.

Test Plan:
- Reset low for 2 cycles with Start=1, then release → all outputs 0, Busy=0, no strobes.
- MEM_LAT=2; Start with kLOD, AddrIn=0x10, Rtaddr=5; MemDataIn=0xA5 valid in cycle 2 → MemRdEn high in cycles 1-2 at MemAddr=0x10; in cycle 3 RfWriteEn=1, RfRtaddr=5, RfDataIn=0xA5, RfOperation=kLOD; Done pulses in cycle 4.
- Start with kSTR, AddrIn=0xFF, StoreData=0x3C → MemWrEn=1, MemAddr=0xFF, MemDataOut=0x3C in cycle 1; Done in cycle 2; RfWriteEn stays 0 throughout.
- Start with an illegal opcode 0xF → Err=1 for one cycle, Busy stays 0, all memory and register-file strobes stay 0.
- Start re-pulsed every cycle during a load → only the first command executes; a second Start in the cycle after DONE is accepted.
- Reset driven low in cycle 2 of a load → cycle 3 is IDLE, no RfWriteEn and no Done appear.

Source files
------------

// File: rtl/ldst_unit_pkg.sv
// Shared definitions for the load/store sequencer: opcodes common with the
// decoder and register file, plus the sequencer state encoding.
package ldst_unit_pkg;

  localparam logic [3:0] kLOD = 4'h4;
  localparam logic [3:0] kSTR = 4'h5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WB   = 3'd2,
    ST   = 3'd3,
    DONE = 3'd4
  } ldst_state_t;

endpackage

// File: rtl/ldst_unit.sv
// Load/store sequencer: one command per transaction, drives the data-memory
// port and, for loads, the register-file write strobe after MEM_LAT cycles.
module ldst_unit
  import ldst_unit_pkg::*;
#(
  parameter int W       = 8,
  parameter int A       = 4,
  parameter int MEM_LAT = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [3:0]   Operation,
  input  logic [A-1:0] Rtaddr,
  input  logic [W-1:0] AddrIn,
  input  logic [W-1:0] StoreData,
  output logic         Busy,
  output logic         Done,
  output logic         Err,
  output logic [W-1:0] MemAddr,
  output logic         MemRdEn,
  output logic         MemWrEn,
  output logic [W-1:0] MemDataOut,
  input  logic [W-1:0] MemDataIn,
  output logic         RfWriteEn,
  output logic         RfOp,
  output logic [3:0]   RfOperation,
  output logic [A-1:0] RfRtaddr,
  output logic [W-1:0] RfDataIn
);

  localparam int CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  ldst_state_t    state;
  logic [W-1:0]   addr_q;
  logic [W-1:0]   data_q;
  logic [W-1:0]   rdata_q;
  logic [A-1:0]   rt_q;
  logic [CW-1:0]  cnt;
  logic           err_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      rt_q    <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            addr_q <= AddrIn;
            data_q <= StoreData;
            rt_q   <= Rtaddr;
            if (Operation == kLOD) begin
              state <= RD;
              cnt   <= CNT_INIT;
            end else if (Operation == kSTR) begin
              state <= ST;
            end else begin
              // illegal opcode: flag it and stay put, no bus activity
              err_q <= 1'b1;
            end
          end
        end
        RD: begin
          if (cnt == '0) begin
            rdata_q <= MemDataIn;
            state   <= WB;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WB:      state <= DONE;
        ST:      state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy        = (state != IDLE);
  assign Done        = (state == DONE);
  assign Err         = err_q;
  assign MemRdEn     = (state == RD);
  assign MemWrEn     = (state == ST);
  assign MemAddr     = addr_q;
  assign MemDataOut  = data_q;
  assign RfWriteEn   = (state == WB);
  assign RfOp        = 1'b0;
  assign RfOperation = (state == WB) ? kLOD : 4'h0;
  assign RfRtaddr    = rt_q;
  assign RfDataIn    = rdata_q;

endmodule

// File: tb/tb_ldst_unit.sv
// Directed bench for ldst_unit: reset, load, store, illegal opcode,
// start-while-busy and mid-load reset.
module tb_ldst_unit;
  import ldst_unit_pkg::*;

  localparam int W = 8;
  localparam int A = 4;

  logic         Clk = 1'b0;
  logic         Reset, Start;
  logic [3:0]   Operation;
  logic [A-1:0] Rtaddr;
  logic [W-1:0] AddrIn, StoreData, MemDataIn;
  logic         Busy, Done, Err, MemRdEn, MemWrEn, RfWriteEn, RfOp;
  logic [W-1:0] MemAddr, MemDataOut, RfDataIn;
  logic [3:0]   RfOperation;
  logic [A-1:0] RfRtaddr;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  ldst_unit #(.W(W), .A(A), .MEM_LAT(2)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Operation(Operation),
    .Rtaddr(Rtaddr), .AddrIn(AddrIn), .StoreData(StoreData),
    .Busy(Busy), .Done(Done), .Err(Err), .MemAddr(MemAddr),
    .MemRdEn(MemRdEn), .MemWrEn(MemWrEn), .MemDataOut(MemDataOut),
    .MemDataIn(MemDataIn), .RfWriteEn(RfWriteEn), .RfOp(RfOp),
    .RfOperation(RfOperation), .RfRtaddr(RfRtaddr), .RfDataIn(RfDataIn)
  );

  // strobe vector: {Busy, MemRdEn, MemWrEn, RfWriteEn, Done, Err}
  logic [5:0] strb;
  assign strb = {Busy, MemRdEn, MemWrEn, RfWriteEn, Done, Err};

  // Inputs change and outputs are sampled at the negedge (mid-cycle).
  task automatic test_reset();
    Reset = 1'b0; Start = 1'b1; Operation = kLOD;
    AddrIn = 8'h33; StoreData = 8'h44; Rtaddr = 4'd7; MemDataIn = 8'h55;
    repeat (2) @(negedge Clk);
    total++;
    if (strb !== 6'b0 || MemAddr !== 8'h0 || MemDataOut !== 8'h0 ||
        RfDataIn !== 8'h0 || RfRtaddr !== 4'h0 || RfOperation !== 4'h0 || RfOp !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: strb=%b addr=%h mdo=%h rfd=%h rt=%h rfop=%h op=%b expected all 0",
               strb, MemAddr, MemDataOut, RfDataIn, RfRtaddr, RfOperation, RfOp);
    end
    Reset = 1'b1; Start = 1'b0;
    @(negedge Clk);
    total++;
    if (strb !== 6'b0 || MemAddr !== 8'h0 || RfDataIn !== 8'h0) begin
      bad++;
      $display("FAIL reset_release: strb=%b addr=%h rfd=%h expected 000000/00/00", strb, MemAddr, RfDataIn);
    end
  endtask

  task automatic test_load();
    Start = 1'b1; Operation = kLOD; AddrIn = 8'h10; Rtaddr = 4'd5; StoreData = 8'h00;
    MemDataIn = 8'h11;
    @(negedge Clk);  // cycle 1
    Start = 1'b0; AddrIn = 8'h00; Rtaddr = 4'd0;
    total++;
    if (strb !== 6'b110000 || MemAddr !== 8'h10) begin
      bad++;
      $display("FAIL load_c1: strb=%b addr=%h expected 110000/10", strb, MemAddr);
    end
    MemDataIn = 8'hA5;
    @(negedge Clk);  // cycle 2
    total++;
    if (strb !== 6'b110000 || MemAddr !== 8'h10) begin
      bad++;
      $display("FAIL load_c2: strb=%b addr=%h expected 110000/10", strb, MemAddr);
    end
    @(negedge Clk);  // cycle 3: writeback
    MemDataIn = 8'h00;
    total++;
    if (strb !== 6'b100100 || RfRtaddr !== 4'd5 || RfDataIn !== 8'hA5 ||
        RfOperation !== kLOD || RfOp !== 1'b0) begin
      bad++;
      $display("FAIL load_wb: strb=%b rt=%0d data=%h rfop=%h op=%b expected 100100/5/a5/%h/0",
               strb, RfRtaddr, RfDataIn, RfOperation, RfOp, kLOD);
    end
    @(negedge Clk);  // cycle 4: done
    total++;
    if (strb !== 6'b100010 || RfOperation !== 4'h0 || RfDataIn !== 8'hA5) begin
      bad++;
      $display("FAIL load_done: strb=%b rfop=%h rfd=%h expected 100010/0/a5", strb, RfOperation, RfDataIn);
    end
    @(negedge Clk);  // cycle 5: idle
    total++;
    if (strb !== 6'b0) begin
      bad++;
      $display("FAIL load_idle: strb=%b expected 000000", strb);
    end
  endtask

  task automatic test_store();
    Start = 1'b1; Operation = kSTR; AddrIn = 8'hFF; StoreData = 8'h3C; Rtaddr = 4'd2;
    @(negedge Clk);  // cycle 1
    Start = 1'b0; AddrIn = 8'h00; StoreData = 8'h00;
    total++;
    if (strb !== 6'b101000 || MemAddr !== 8'hFF || MemDataOut !== 8'h3C) begin
      bad++;
      $display("FAIL store_c1: strb=%b addr=%h data=%h expected 101000/ff/3c", strb, MemAddr, MemDataOut);
    end
    @(negedge Clk);  // cycle 2
    total++;
    if (strb !== 6'b100010) begin
      bad++;
      $display("FAIL store_done: strb=%b expected 100010", strb);
    end
    @(negedge Clk);  // cycle 3
    total++;
    if (strb !== 6'b0 || MemDataOut !== 8'h3C) begin
      bad++;
      $display("FAIL store_idle: strb=%b mdo=%h expected 000000/3c", strb, MemDataOut);
    end
  endtask

  task automatic test_illegal();
    Start = 1'b1; Operation = 4'hF; AddrIn = 8'h21;
    @(negedge Clk);
    Start = 1'b0;
    total++;
    if (strb !== 6'b000001 || RfOperation !== 4'h0) begin
      bad++;
      $display("FAIL illegal_err: strb=%b rfop=%h expected 000001/0", strb, RfOperation);
    end
    @(negedge Clk);
    total++;
    if (strb !== 6'b0) begin
      bad++;
      $display("FAIL illegal_after: strb=%b expected 000000", strb);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_s [4];
    exp_s[0] = 6'b110000; exp_s[1] = 6'b110000; exp_s[2] = 6'b100100; exp_s[3] = 6'b100010;
    Start = 1'b1; Operation = kLOD; AddrIn = 8'h20; Rtaddr = 4'd3; MemDataIn = 8'h6B;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);  // cycles 1..4, Start kept high with a different command
      Operation = kSTR; AddrIn = 8'h77; StoreData = 8'h99; Rtaddr = 4'd9;
      total++;
      if (strb !== exp_s[c] || MemAddr !== 8'h20 || RfRtaddr !== 4'd3) begin
        bad++;
        $display("FAIL b2b_c%0d: strb=%b addr=%h rt=%0d expected %b/20/3",
                 c + 1, strb, MemAddr, RfRtaddr, exp_s[c]);
      end
    end
    AddrIn = 8'h42; StoreData = 8'h5A;
    @(negedge Clk);  // cycle 5: idle, new Start sampled at its end
    total++;
    if (strb !== 6'b0 || RfDataIn !== 8'h6B) begin
      bad++;
      $display("FAIL b2b_idle: strb=%b rfd=%h expected 000000/6b", strb, RfDataIn);
    end
    @(negedge Clk);  // cycle 6
    Start = 1'b0;
    total++;
    if (strb !== 6'b101000 || MemAddr !== 8'h42 || MemDataOut !== 8'h5A) begin
      bad++;
      $display("FAIL b2b_second: strb=%b addr=%h data=%h expected 101000/42/5a", strb, MemAddr, MemDataOut);
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset_mid_load();
    Start = 1'b1; Operation = kLOD; AddrIn = 8'h30; Rtaddr = 4'd6; MemDataIn = 8'hC3;
    @(negedge Clk);  // cycle 1
    Start = 1'b0;
    total++;
    if (strb !== 6'b110000) begin
      bad++;
      $display("FAIL rst_mid_c1: strb=%b expected 110000", strb);
    end
    @(negedge Clk);  // cycle 2: pull reset
    Reset = 1'b0;
    @(negedge Clk);  // cycle 3
    Reset = 1'b1;
    total++;
    if (strb !== 6'b0 || MemAddr !== 8'h0 || RfDataIn !== 8'h0) begin
      bad++;
      $display("FAIL rst_mid_c3: strb=%b addr=%h rfd=%h expected 000000/00/00", strb, MemAddr, RfDataIn);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      total++;
      if (strb !== 6'b0) begin
        bad++;
        $display("FAIL rst_mid_after%0d: strb=%b expected 000000", c, strb);
      end
    end
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Operation = 4'h0; Rtaddr = '0;
    AddrIn = '0; StoreData = '0; MemDataIn = '0;
    @(negedge Clk);
    test_reset();
    test_load();
    test_store();
    test_illegal();
    test_back_to_back();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
